// File: rtl/tt_um_emern_frontend_dbuf.sv
// SPI command frontend with a shadow/active double-buffered scene: frames land in shadow, commit on vblank.
// Optional macro FRONTEND_READBACK_EN adds a status shifter ({pending, err_count[6:0]}) on miso_out.
module tt_um_emern_frontend_dbuf #(
  parameter int N_POLY = 3,
  parameter int WCOLOR = 6,
  parameter int WPX    = 7,
  parameter int WPY    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs_in,
  input  logic                     mosi_in,
  input  logic                     sck_in,
  output logic                     miso_out,
  input  logic                     en_load,
  input  logic                     frame_sync,
  output logic [WCOLOR-1:0]        bg_color_out,
  output logic [WCOLOR*N_POLY-1:0] poly_color_out,
  output logic [WPX*N_POLY-1:0]    v0_x_out,
  output logic [WPX*N_POLY-1:0]    v1_x_out,
  output logic [WPX*N_POLY-1:0]    v2_x_out,
  output logic [WPY*N_POLY-1:0]    v0_y_out,
  output logic [WPY*N_POLY-1:0]    v1_y_out,
  output logic [WPY*N_POLY-1:0]    v2_y_out,
  output logic [N_POLY-1:0]        poly_enable_out,
  output logic                     pending_out,
  output logic [7:0]               err_count_out
);

  localparam int PAYLOAD    = WCOLOR + 3*WPX + 3*WPY;
  localparam int FRAME_BITS = 8 + PAYLOAD;
  localparam int CW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [6:0]    SLOT_LIM = 7'(N_POLY);

  localparam int O_COL = 8;
  localparam int O_X0  = O_COL + WCOLOR;
  localparam int O_X1  = O_X0 + WPX;
  localparam int O_X2  = O_X1 + WPX;
  localparam int O_Y0  = O_X2 + WPX;
  localparam int O_Y1  = O_Y0 + WPY;
  localparam int O_Y2  = O_Y1 + WPY;

  // input synchronisers
  logic [2:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       cs_high;
  logic       mosi_bit;
  logic       sck_rise;

  // Synchronise the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck_in};
      cs_sync   <= {cs_sync[0], cs_in};
      mosi_sync <= {mosi_sync[0], mosi_in};
    end
  end

  assign cs_high  = cs_sync[1];
  assign mosi_bit = mosi_sync[1];
  assign sck_rise = (sck_sync[2:1] == 2'b01);

  // frame shifter
  logic [FRAME_BITS-1:0] shift_buf;
  logic [CW-1:0]         bit_cnt;
  logic                  exec;

  // Shift in frame bits; exec pulses once, the cycle after the last bit lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_buf <= '0;
      bit_cnt   <= '0;
      exec      <= 1'b0;
    end else if (cs_high) begin
      shift_buf <= '0;
      bit_cnt   <= '0;
      exec      <= 1'b0;
    end else if (sck_rise && en_load && (bit_cnt != CNT_MAX)) begin
      shift_buf <= {shift_buf[FRAME_BITS-2:0], mosi_bit};
      bit_cnt   <= bit_cnt + CW'(1);
      exec      <= (bit_cnt == CNT_LAST);
    end else begin
      exec      <= 1'b0;
    end
  end

  logic [FRAME_BITS-1:0] frame;

  // First bit received sits at the buffer MSB; reverse so the frame reads LSB-first
  always_comb begin
    frame = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      frame[i] = shift_buf[FRAME_BITS-1-i];
    end
  end

  logic [7:0]        cmd;
  logic [5:0]        slot;
  logic [WCOLOR-1:0] f_col;
  logic [WPX-1:0]    f_x0, f_x1, f_x2;
  logic [WPY-1:0]    f_y0, f_y1, f_y2;

  assign cmd   = frame[7:0];
  assign slot  = cmd[5:0];
  assign f_col = frame[O_COL +: WCOLOR];
  assign f_x0  = frame[O_X0 +: WPX];
  assign f_x1  = frame[O_X1 +: WPX];
  assign f_x2  = frame[O_X2 +: WPX];
  assign f_y0  = frame[O_Y0 +: WPY];
  assign f_y1  = frame[O_Y1 +: WPY];
  assign f_y2  = frame[O_Y2 +: WPY];

  logic slot_ok;
  logic do_write, do_clear, do_bg, do_clr_all, do_commit_now, do_err;
  logic shadow_dirty;

  assign slot_ok = ({1'b0, slot} < SLOT_LIM);

  // Command decode, qualified by the exec pulse
  always_comb begin
    do_write      = 1'b0;
    do_clear      = 1'b0;
    do_bg         = 1'b0;
    do_clr_all    = 1'b0;
    do_commit_now = 1'b0;
    do_err        = 1'b0;
    if (exec) begin
      case (cmd[7:6])
        2'b10: begin
          if (slot_ok) do_write = 1'b1;
          else         do_err   = 1'b1;
        end
        2'b01: begin
          if (slot_ok) do_clear = 1'b1;
          else         do_err   = 1'b1;
        end
        2'b00: begin
          case (cmd[5:0])
            6'h01:   do_bg         = 1'b1;
            6'h02:   do_clr_all    = 1'b1;
            6'h03:   do_commit_now = 1'b1;
            default: do_err        = 1'b1;
          endcase
        end
        default: do_err = 1'b1;
      endcase
    end else begin
      do_err = 1'b0;
    end
  end

  assign shadow_dirty = do_write | do_clear | do_bg | do_clr_all;

  // shadow bank
  logic [WCOLOR-1:0]        sh_bg;
  logic [WCOLOR*N_POLY-1:0] sh_col;
  logic [WPX*N_POLY-1:0]    sh_x0, sh_x1, sh_x2;
  logic [WPY*N_POLY-1:0]    sh_y0, sh_y1, sh_y2;
  logic [N_POLY-1:0]        sh_en;

  // Shadow bank updates from decoded commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bg  <= '0;
      sh_col <= '0;
      sh_x0  <= '0;
      sh_x1  <= '0;
      sh_x2  <= '0;
      sh_y0  <= '0;
      sh_y1  <= '0;
      sh_y2  <= '0;
      sh_en  <= '0;
    end else begin
      if (do_bg) sh_bg <= f_col;
      if (do_clr_all) begin
        sh_col <= '0;
        sh_x0  <= '0;
        sh_x1  <= '0;
        sh_x2  <= '0;
        sh_y0  <= '0;
        sh_y1  <= '0;
        sh_y2  <= '0;
        sh_en  <= '0;
      end
      for (int i = 0; i < N_POLY; i++) begin
        if (slot == 6'(i)) begin
          if (do_write) begin
            sh_col[i*WCOLOR +: WCOLOR] <= f_col;
            sh_x0[i*WPX +: WPX]        <= f_x0;
            sh_x1[i*WPX +: WPX]        <= f_x1;
            sh_x2[i*WPX +: WPX]        <= f_x2;
            sh_y0[i*WPY +: WPY]        <= f_y0;
            sh_y1[i*WPY +: WPY]        <= f_y1;
            sh_y2[i*WPY +: WPY]        <= f_y2;
            sh_en[i]                   <= 1'b1;
          end else if (do_clear) begin
            sh_col[i*WCOLOR +: WCOLOR] <= '0;
            sh_x0[i*WPX +: WPX]        <= '0;
            sh_x1[i*WPX +: WPX]        <= '0;
            sh_x2[i*WPX +: WPX]        <= '0;
            sh_y0[i*WPY +: WPY]        <= '0;
            sh_y1[i*WPY +: WPY]        <= '0;
            sh_y2[i*WPY +: WPY]        <= '0;
            sh_en[i]                   <= 1'b0;
          end
        end
      end
    end
  end

  logic commit_now_r;
  logic commit;

  // COMMIT_NOW lands one clock after its exec, after any same-cycle shadow write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) commit_now_r <= 1'b0;
    else        commit_now_r <= do_commit_now;
  end

  assign commit = commit_now_r | (frame_sync & pending_out);

  // Active bank: nonblocking copy means a same-cycle exec is not seen until the next commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_color_out    <= '0;
      poly_color_out  <= '0;
      v0_x_out        <= '0;
      v1_x_out        <= '0;
      v2_x_out        <= '0;
      v0_y_out        <= '0;
      v1_y_out        <= '0;
      v2_y_out        <= '0;
      poly_enable_out <= '0;
    end else if (commit) begin
      bg_color_out    <= sh_bg;
      poly_color_out  <= sh_col;
      v0_x_out        <= sh_x0;
      v1_x_out        <= sh_x1;
      v2_x_out        <= sh_x2;
      v0_y_out        <= sh_y0;
      v1_y_out        <= sh_y1;
      v2_y_out        <= sh_y2;
      poly_enable_out <= sh_en;
    end
  end

  // Pending: a shadow write wins over a commit in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pending_out <= 1'b0;
    else if (shadow_dirty) pending_out <= 1'b1;
    else if (commit)       pending_out <= 1'b0;
  end

  // Saturating count of rejected commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_count_out <= 8'h00;
    else if (do_err && (err_count_out != 8'hFF)) err_count_out <= err_count_out + 8'h01;
  end

`ifdef FRONTEND_READBACK_EN
  logic       cs_prev;
  logic       sck_fall;
  logic [7:0] status_sr;

  assign sck_fall = (sck_sync[2:1] == 2'b10);

  // Status shifter: snapshot on cs fall, shift out LSB-first on sck falls, idle at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev   <= 1'b1;
      status_sr <= 8'h00;
    end else begin
      cs_prev <= cs_high;
      if (cs_high)       status_sr <= 8'h00;
      else if (cs_prev)  status_sr <= {pending_out, err_count_out[6:0]};
      else if (sck_fall) status_sr <= {1'b0, status_sr[7:1]};
    end
  end

  assign miso_out = status_sr[0];
`else
  assign miso_out = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_emern_frontend_dbuf.sv
// Self-checking bench for tt_um_emern_frontend_dbuf: directed table, corner sequences, random frames vs a scene model.
module tb_tt_um_emern_frontend_dbuf;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst_n, cs_in, mosi_in, sck_in, en_load, frame_sync;
  logic miso_out;
  logic [5:0]  bg_color_out;
  logic [17:0] poly_color_out;
  logic [20:0] v0_x_out, v1_x_out, v2_x_out;
  logic [17:0] v0_y_out, v1_y_out, v2_y_out;
  logic [2:0]  poly_enable_out;
  logic        pending_out;
  logic [7:0]  err_count_out;

  always #5 clk = ~clk;

  tt_um_emern_frontend_dbuf dut (
    .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .mosi_in(mosi_in), .sck_in(sck_in),
    .miso_out(miso_out), .en_load(en_load), .frame_sync(frame_sync),
    .bg_color_out(bg_color_out), .poly_color_out(poly_color_out),
    .v0_x_out(v0_x_out), .v1_x_out(v1_x_out), .v2_x_out(v2_x_out),
    .v0_y_out(v0_y_out), .v1_y_out(v1_y_out), .v2_y_out(v2_y_out),
    .poly_enable_out(poly_enable_out), .pending_out(pending_out), .err_count_out(err_count_out)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- scene model ----------------
  typedef struct packed {
    logic       en;
    logic [5:0] col;
    logic [6:0] x0, x1, x2;
    logic [5:0] y0, y1, y2;
  } slot_t;

  slot_t      m_sh[NP];
  slot_t      m_ac[NP];
  logic [5:0] m_sh_bg, m_ac_bg;
  bit         m_pend;
  int         m_err;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end
    m_sh_bg = '0;
    m_ac_bg = '0;
    m_pend  = 0;
    m_err   = 0;
  endtask

  task automatic model_copy();
    for (int i = 0; i < NP; i++) m_ac[i] = m_sh[i];
    m_ac_bg = m_sh_bg;
    m_pend  = 0;
  endtask

  task automatic model_exec(input logic [52:0] f);
    int    c, kind, idx;
    slot_t s;
    c    = int'(f[7:0]);
    kind = c / 64;
    idx  = c % 64;
    s    = '{en: 1'b1, col: f[13:8], x0: f[20:14], x1: f[27:21], x2: f[34:28],
             y0: f[40:35], y1: f[46:41], y2: f[52:47]};
    if (kind == 2 && idx < NP) begin
      m_sh[idx] = s;
      m_pend = 1;
    end else if (kind == 1 && idx < NP) begin
      m_sh[idx] = '0;
      m_pend = 1;
    end else if (c == 1) begin
      m_sh_bg = f[13:8];
      m_pend = 1;
    end else if (c == 2) begin
      for (int i = 0; i < NP; i++) m_sh[i] = '0;
      m_pend = 1;
    end else if (c == 3) begin
      model_copy();
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic model_sync();
    if (m_pend) model_copy();
  endtask

  task automatic check_all(input string tag);
    logic [63:0] ec, ex0, ex1, ex2, ey0, ey1, ey2, een;
    ec = '0; ex0 = '0; ex1 = '0; ex2 = '0; ey0 = '0; ey1 = '0; ey2 = '0; een = '0;
    for (int i = 0; i < NP; i++) begin
      ec[i*6 +: 6]  = m_ac[i].col;
      ex0[i*7 +: 7] = m_ac[i].x0;
      ex1[i*7 +: 7] = m_ac[i].x1;
      ex2[i*7 +: 7] = m_ac[i].x2;
      ey0[i*6 +: 6] = m_ac[i].y0;
      ey1[i*6 +: 6] = m_ac[i].y1;
      ey2[i*6 +: 6] = m_ac[i].y2;
      een[i]        = m_ac[i].en;
    end
    check({tag, ".bg"},    bg_color_out,    64'(m_ac_bg));
    check({tag, ".color"}, poly_color_out,  ec);
    check({tag, ".v0x"},   v0_x_out,        ex0);
    check({tag, ".v1x"},   v1_x_out,        ex1);
    check({tag, ".v2x"},   v2_x_out,        ex2);
    check({tag, ".v0y"},   v0_y_out,        ey0);
    check({tag, ".v1y"},   v1_y_out,        ey1);
    check({tag, ".v2y"},   v2_y_out,        ey2);
    check({tag, ".en"},    poly_enable_out, een);
    check({tag, ".pend"},  pending_out,     64'(m_pend));
    check({tag, ".err"},   err_count_out,   64'(m_err));
    check({tag, ".miso"},  miso_out,        64'd0);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [52:0] mk_frame(input logic [7:0] c, input logic [5:0] col,
                                           input logic [6:0] x0, input logic [6:0] x1, input logic [6:0] x2,
                                           input logic [5:0] y0, input logic [5:0] y1, input logic [5:0] y2);
    return {y2, y1, y0, x2, x1, x0, col, c};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    mosi_in = b;
    sck_in  = 1'b0;
    tick(4);
    sck_in  = 1'b1;
    tick(4);
  endtask

  task automatic spi_frame(input logic [52:0] f, input int nbits);
    cs_in = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < 53) spi_bit(f[i]);
      else        spi_bit(1'($urandom_range(0, 1)));
    end
    sck_in = 1'b0;
    tick(4);
    cs_in = 1'b1;
    tick(8);
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    tick(2);
    model_sync();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cs_in = 1'b1;
    sck_in = 1'b0;
    mosi_in = 1'b0;
    en_load = 1'b1;
    frame_sync = 1'b0;
    tick(3);
    rst_n = 1'b1;
    model_reset();
    tick(3);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [5:0] col;
    logic [6:0] x0, x1, x2;
    logic [5:0] y0, y1, y2;
    bit         sync;
    bit         exp_pend;
    int         exp_err;
  } vec_t;

  vec_t        tbl[12];
  logic [52:0] f;
  logic [7:0]  rb_exp;
  int          e0, mode, nb, pick;
  logic [7:0]  rc;

  initial begin
    tbl[0]  = '{8'h81, 6'h2A, 7'd10,  7'd20, 7'd30, 6'd5,  6'd15, 6'd25, 1'b0, 1'b1, 0};
    tbl[1]  = '{8'h85, 6'h11, 7'd1,   7'd2,  7'd3,  6'd4,  6'd5,  6'd6,  1'b0, 1'b1, 1};
    tbl[2]  = '{8'hFF, 6'h22, 7'd7,   7'd8,  7'd9,  6'd10, 6'd11, 6'd12, 1'b0, 1'b1, 2};
    tbl[3]  = '{8'h01, 6'h15, 7'd0,   7'd0,  7'd0,  6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 2};
    tbl[4]  = '{8'h41, 6'h3F, 7'd99,  7'd99, 7'd99, 6'd9,  6'd9,  6'd9,  1'b0, 1'b1, 2};
    tbl[5]  = '{8'h00, 6'h01, 7'd1,   7'd1,  7'd1,  6'd1,  6'd1,  6'd1,  1'b0, 1'b1, 3};
    tbl[6]  = '{8'h43, 6'h02, 7'd2,   7'd2,  7'd2,  6'd2,  6'd2,  6'd2,  1'b1, 1'b0, 4};
    tbl[7]  = '{8'h02, 6'h03, 7'd3,   7'd3,  7'd3,  6'd3,  6'd3,  6'd3,  1'b0, 1'b1, 4};
    tbl[8]  = '{8'h82, 6'h3F, 7'd127, 7'd0,  7'd64, 6'd63, 6'd1,  6'd32, 1'b0, 1'b1, 4};
    tbl[9]  = '{8'h03, 6'h00, 7'd0,   7'd0,  7'd0,  6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 4};
    tbl[10] = '{8'hC1, 6'h05, 7'd5,   7'd5,  7'd5,  6'd5,  6'd5,  6'd5,  1'b0, 1'b0, 5};
    tbl[11] = '{8'h04, 6'h06, 7'd6,   7'd6,  7'd6,  6'd6,  6'd6,  6'd6,  1'b1, 1'b0, 6};

    rst_n = 1'b0; cs_in = 1'b1; sck_in = 1'b0; mosi_in = 1'b0; en_load = 1'b1; frame_sync = 1'b0;
    do_reset();
    check_all("reset");

    // WRITE slot 1 stays invisible until frame_sync
    f = mk_frame(8'h81, 6'h2A, 7'd10, 7'd20, 7'd30, 6'd5, 6'd15, 6'd25);
    spi_frame(f, 53);
    model_exec(f);
    check("wr1.color_before", poly_color_out, 64'd0);
    check("wr1.en_before", poly_enable_out, 64'd0);
    check("wr1.pend_before", pending_out, 64'd1);
    pulse_sync();
    check("wr1.color_slot1", poly_color_out[11:6], 64'h2A);
    check("wr1.v0x_slot1", v0_x_out[13:7], 64'd10);
    check("wr1.en_after", poly_enable_out, 64'b010);
    check("wr1.pend_after", pending_out, 64'd0);
    check_all("wr1");

    // Reset in the middle of a frame
    f = mk_frame(8'h80, 6'h33, 7'd1, 7'd2, 7'd3, 6'd4, 6'd5, 6'd6);
    cs_in = 1'b0;
    tick(4);
    for (int i = 0; i < 20; i++) spi_bit(f[i]);
    rst_n = 1'b0;
    tick(2);
    check("midrst.color", poly_color_out, 64'd0);
    check("midrst.en", poly_enable_out, 64'd0);
    check("midrst.bg", bg_color_out, 64'd0);
    check("midrst.pend", pending_out, 64'd0);
    check("midrst.err", err_count_out, 64'd0);
    cs_in = 1'b1; sck_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_reset();
    tick(4);
    spi_frame(f, 53);
    model_exec(f);
    spi_frame(mk_frame(8'h03, 6'd0, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0), 53);
    model_exec(mk_frame(8'h03, 6'd0, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0));
    check("midrst.en_after", poly_enable_out, 64'b001);
    check_all("midrst");

    // Directed table
    do_reset();
    for (int k = 0; k < 12; k++) begin
      f = mk_frame(tbl[k].cmd, tbl[k].col, tbl[k].x0, tbl[k].x1, tbl[k].x2, tbl[k].y0, tbl[k].y1, tbl[k].y2);
      spi_frame(f, 53);
      model_exec(f);
      if (tbl[k].sync) pulse_sync();
      check($sformatf("tbl%0d.pend", k), pending_out, 64'(tbl[k].exp_pend));
      check($sformatf("tbl%0d.err", k), err_count_out, 64'(tbl[k].exp_err));
      check_all($sformatf("tbl%0d", k));
    end

    // Partial SET_BG discarded, then full SET_BG + COMMIT_NOW
    e0 = m_err;
    spi_frame(mk_frame(8'h01, 6'h2C, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0), 30);
    check("partial.err", err_count_out, 64'(e0));
    check_all("partial");
    f = mk_frame(8'h01, 6'h15, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    spi_frame(f, 53);
    model_exec(f);
    f = mk_frame(8'h03, 6'h00, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    spi_frame(f, 53);
    model_exec(f);
    check("cnow.bg", bg_color_out, 64'h15);
    check_all("cnow");

    // 60 edges in one frame execute once; en_load=0 blocks the frame entirely
    e0 = m_err;
    f = mk_frame(8'hFF, 6'h00, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    spi_frame(f, 60);
    model_exec(f);
    check("extra.err", err_count_out, 64'(e0 + 1));
    en_load = 1'b0;
    spi_frame(f, 53);
    check("noload.err", err_count_out, 64'(e0 + 1));
    spi_frame(mk_frame(8'h80, 6'h3C, 7'd7, 7'd7, 7'd7, 6'd7, 6'd7, 6'd7), 53);
    en_load = 1'b1;
    check_all("noload");

    // Randomised frames against the model
    for (int it = 0; it < 40; it++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2, 8, 9: rc = {2'b10, 6'($urandom_range(0, 4))};
        3:             rc = {2'b01, 6'($urandom_range(0, 4))};
        4:             rc = 8'h01;
        5:             rc = 8'h02;
        6:             rc = 8'h03;
        default:       rc = 8'($urandom_range(0, 255));
      endcase
      f = mk_frame(rc, 6'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
                   6'($urandom), 6'($urandom), 6'($urandom));
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        nb = $urandom_range(1, 52);
        spi_frame(f, nb);
      end else if (mode == 1) begin
        nb = $urandom_range(54, 60);
        spi_frame(f, nb);
        model_exec(f);
      end else if (mode == 2) begin
        en_load = 1'b0;
        spi_frame(f, 53);
        en_load = 1'b1;
      end else begin
        spi_frame(f, 53);
        model_exec(f);
      end
      if ($urandom_range(0, 2) == 0) pulse_sync();
      check_all($sformatf("rnd%0d", it));
    end

`ifdef FRONTEND_READBACK_EN
    // Readback of {pending, err_count[6:0]} with err=3, pending=1
    do_reset();
    f = mk_frame(8'hFF, 6'h00, 7'd0, 7'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      spi_frame(f, 53);
      model_exec(f);
    end
    f = mk_frame(8'h80, 6'h01, 7'd1, 7'd1, 7'd1, 6'd1, 6'd1, 6'd1);
    spi_frame(f, 53);
    model_exec(f);
    rb_exp = 8'b1000_0011;
    cs_in = 1'b0;
    tick(6);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rb.bit%0d", k), miso_out, 64'(rb_exp[k]));
      sck_in = 1'b1;
      tick(4);
      sck_in = 1'b0;
      tick(4);
    end
    cs_in = 1'b1;
    tick(6);
    check_all("rb");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
